// File: rtl/leaf_user_stream_fifo.sv
// -----------------------------------------------------------------------------
// leaf_user_stream_fifo
//   Elastic buffer on the user side of the leaf interface, one per input port.
//   Accepts payload words from the leaf interface (vld/ack) and presents them
//   in order to the user kernel (vld/ack), first-word-fall-through.
//   Everything is in the clk_user domain.
//
// Ports
//   clk_user            in   user clock, rising edge
//   reset               in   asynchronous, active-low reset
//   din_interface2fifo  in   word from leaf interface
//   vld_interface2fifo  in   din_interface2fifo valid
//   ack_fifo2interface  out  buffer can accept a word this cycle
//   dout_fifo2user      out  head word to user kernel
//   vld_fifo2user       out  dout_fifo2user valid
//   ack_user2fifo       in   user kernel accepts head word
//   occupancy           out  words currently stored (0..2**DEPTH_BITS)
//   almost_full         out  occupancy >= ALMOST_FULL_LVL
//   word_count          out  words delivered to user since reset (wraps)
// -----------------------------------------------------------------------------
module leaf_user_stream_fifo #(
   parameter int PAYLOAD_BITS    = 32,
   parameter int DEPTH_BITS      = 4,
   parameter int ALMOST_FULL_LVL = 12
) (
   input  logic                    clk_user,
   input  logic                    reset,
   input  logic [PAYLOAD_BITS-1:0] din_interface2fifo,
   input  logic                    vld_interface2fifo,
   output logic                    ack_fifo2interface,
   output logic [PAYLOAD_BITS-1:0] dout_fifo2user,
   output logic                    vld_fifo2user,
   input  logic                    ack_user2fifo,
   output logic [DEPTH_BITS:0]     occupancy,
   output logic                    almost_full,
   output logic [31:0]             word_count
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0]   OCC_FULL = (DEPTH_BITS+1)'(DEPTH);
   localparam logic [DEPTH_BITS:0]   OCC_AF   = (DEPTH_BITS+1)'(ALMOST_FULL_LVL);
   localparam logic [DEPTH_BITS:0]   OCC_ONE  = (DEPTH_BITS+1)'(1);
   localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
   localparam logic [31:0]           WC_ONE   = 32'd1;

   logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
   logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]     occ_q, occ_d;
   logic                    af_q, af_d;
   logic [31:0]             wc_q, wc_d;
   // Holds ack low while in reset and rises on the first edge after release.
   logic                    rdy_q;
   logic                    wr_en, rd_en;

   // Both handshakes are derived from registered state only, so there is no
   // combinational path from ack_user2fifo to ack_fifo2interface.
   assign ack_fifo2interface = rdy_q && (occ_q != OCC_FULL);
   assign vld_fifo2user      = (occ_q != '0);
   assign dout_fifo2user     = mem_q[rd_ptr_q];
   assign occupancy          = occ_q;
   assign almost_full        = af_q;
   assign word_count         = wc_q;

   assign wr_en = vld_interface2fifo && ack_fifo2interface;
   assign rd_en = vld_fifo2user && ack_user2fifo;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      wc_d     = wc_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         wc_d     = wc_q + WC_ONE;
      end
      case ({wr_en, rd_en})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
      // Registered so almost_full is glitch-free and exactly tracks occupancy.
      af_d = (occ_d >= OCC_AF);
   end

   always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         af_q     <= 1'b0;
         wc_q     <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         af_q     <= af_d;
         wc_q     <= wc_d;
         rdy_q    <= 1'b1;
      end
   end

   // Storage is cleared on reset so dout reads as zero while in reset.
   always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= din_interface2fifo;
      end
   end

endmodule

// File: tb/tb_leaf_user_stream_fifo.sv
module tb_leaf_user_stream_fifo;

   logic        clk_user = 1'b0;
   logic        reset;
   logic [31:0] din_interface2fifo;
   logic        vld_interface2fifo;
   logic        ack_fifo2interface;
   logic [31:0] dout_fifo2user;
   logic        vld_fifo2user;
   logic        ack_user2fifo;
   logic [4:0]  occupancy;
   logic        almost_full;
   logic [31:0] word_count;

   always #5 clk_user = ~clk_user;

   leaf_user_stream_fifo #(
      .PAYLOAD_BITS(32), .DEPTH_BITS(4), .ALMOST_FULL_LVL(12)
   ) dut (
      .clk_user           (clk_user),
      .reset              (reset),
      .din_interface2fifo (din_interface2fifo),
      .vld_interface2fifo (vld_interface2fifo),
      .ack_fifo2interface (ack_fifo2interface),
      .dout_fifo2user     (dout_fifo2user),
      .vld_fifo2user      (vld_fifo2user),
      .ack_user2fifo      (ack_user2fifo),
      .occupancy          (occupancy),
      .almost_full        (almost_full),
      .word_count         (word_count)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: ordered queue of stored words plus delivered count
   logic [31:0] mq [$];
   bit          m_rdy;
   logic [31:0] m_wc;
   int          rd_total;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_rdy    = 1'b0;
      m_wc     = '0;
      rd_total = 0;
   endtask

   // Called on a negedge: check outputs against the model, drive inputs,
   // advance one clock and update the model, return on the next negedge.
   task automatic step(input bit vin, input logic [31:0] d, input bit au, output bit acc);
      bit e_vld, e_ack;
      e_vld = (mq.size() != 0);
      e_ack = m_rdy && (mq.size() != 16);
      chk("occupancy", occupancy, mq.size());
      chk("vld_fifo2user", vld_fifo2user, e_vld);
      chk("ack_fifo2interface", ack_fifo2interface, e_ack);
      chk("almost_full", almost_full, mq.size() >= 12);
      chk("word_count", word_count, m_wc);
      if (e_vld) chk("dout_fifo2user", dout_fifo2user, mq[0]);
      vld_interface2fifo = vin;
      din_interface2fifo = d;
      ack_user2fifo      = au;
      @(posedge clk_user);
      acc = vin && e_ack;
      if (e_vld && au) begin
         void'(mq.pop_front());
         m_wc = m_wc + 32'd1;
         rd_total++;
      end
      if (acc) mq.push_back(d);
      m_rdy = 1'b1;
      @(negedge clk_user);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_occ"}, occupancy, 0);
      chk({tag, "_vld"}, vld_fifo2user, 0);
      chk({tag, "_dout"}, dout_fifo2user, 0);
      chk({tag, "_af"}, almost_full, 0);
      chk({tag, "_wc"}, word_count, 0);
      chk({tag, "_ack"}, ack_fifo2interface, 0);
   endtask

   bit          acc;
   int          idx;
   bit          pend;
   logic [31:0] pword;
   logic [31:0] wc_before;

   initial begin
      reset = 1'b0;
      din_interface2fifo = '0;
      vld_interface2fifo = 1'b0;
      ack_user2fifo = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_user);
      check_reset_outputs("por");
      reset = 1'b1;

      // reset mid-stream with 5 words stored and 2 already delivered
      step(0, 0, 0, acc);
      for (int i = 0; i < 7; i++) step(1, 32'hA000 + i, 0, acc);
      step(0, 0, 1, acc);
      step(0, 0, 1, acc);
      chk("pre_rst_occ", occupancy, 5);
      chk("pre_rst_wc", word_count, 2);
      vld_interface2fifo = 1'b1;
      din_interface2fifo = 32'hDEAD;
      #2 reset = 1'b0;
      #1 check_reset_outputs("mid_rst");
      model_reset();
      @(negedge clk_user);
      check_reset_outputs("hold_rst");
      reset = 1'b1;
      step(0, 0, 0, acc);           // ack still low before first edge
      chk("ack_after_release", ack_fifo2interface, 1);

      // passthrough
      for (int i = 1; i <= 16; i++) begin
         chk("pass_occ_le1", occupancy <= 1, 1);
         step(1, i, 1, acc);
      end
      step(0, 0, 1, acc);
      step(0, 0, 1, acc);
      chk("pass_wc16", word_count, 16);

      // fill to full with the kernel stalled
      idx = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 32'h100 + idx, 0, acc);
         if (acc) idx++;
      end
      chk("fill_accepted", idx, 16);
      chk("full_occ", occupancy, 16);
      chk("full_ack", ack_fifo2interface, 0);
      chk("full_af", almost_full, 1);

      // read at full with the 17th word offered
      step(1, 32'h100 + idx, 1, acc);
      chk("sim_occ15", occupancy, 15);
      chk("sim_ack_rise", ack_fifo2interface, 1);
      step(1, 32'h100 + idx, 0, acc);
      chk("sim_occ16", occupancy, 16);
      for (int i = 0; i < 20 && mq.size() != 0; i++) step(0, 0, 1, acc);
      chk("drained", occupancy, 0);

      // random traffic; producer holds vld/data until accepted
      pend = 0;
      pword = '0;
      for (int i = 0; i < 10000; i++) begin
         if (!pend && $urandom_range(1) == 1) begin
            pend  = 1;
            pword = $urandom;
         end
         step(pend, pword, $urandom_range(1) == 1, acc);
         if (acc) pend = 0;
      end
      for (int i = 0; i < 20 && mq.size() != 0; i++) step(0, 0, 1, acc);
      chk("rand_drained", occupancy, 0);
      chk("rand_wc_eq_reads", word_count, rd_total);

      // kernel acks while empty
      wc_before = m_wc;
      for (int i = 0; i < 4; i++) step(0, 0, 1, acc);
      chk("empty_occ", occupancy, 0);
      chk("empty_vld", vld_fifo2user, 0);
      chk("empty_wc", word_count, wc_before);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
